sem_param_ctrl: RTL and testbench

//  Parametrised two-approach traffic-light controller; next generation of the 5-bit single-approach SEM.
//  One down-counter per phase, a Moore FSM and decoded lamp outputs for main and cross roads.

---
 rtl/sem_param_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sem_param_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sem_param_ctrl.sv
// ---------------------------------------------------------------------------
// sem_param_ctrl
//   Two-approach traffic-light controller (main road / cross road) with a
//   latched pedestrian request and a flashing-yellow maintenance mode.
//   Each phase is timed by one down-counter that is loaded with T-1 on
//   entry and left when it reaches 0, so a phase lasts exactly T cycles.
//
// Ports
//   ck          in   clock, rising edge
//   rst         in   synchronous reset, active-high
//   flash       in   1 = flashing-yellow mode (level)
//   ped_req     in   pedestrian request (pulse or level)
//   main_r/y/g  out  main-road lamps
//   cross_r/y/g out  cross-road lamps
//   ped_walk    out  pedestrian walk lamp
//   ped_ack     out  1-cycle pulse on the first cycle of the walk phase
//   ped_pend    out  request latched and not yet served
//   remain      out  current phase counter value
//   phase_end   out  last cycle of the current phase (remain == 0)
//   state       out  FSM state code (debug)
// ---------------------------------------------------------------------------
module sem_param_ctrl #(
    parameter int CNT_W      = 5,
    parameter int T_MGREEN   = 8,
    parameter int T_CGREEN   = 6,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 2,
    parameter int T_PED      = 5,
    parameter int FLASH_HALF = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             flash,
    input  logic             ped_req,
    output logic             main_r,
    output logic             main_y,
    output logic             main_g,
    output logic             cross_r,
    output logic             cross_y,
    output logic             cross_g,
    output logic             ped_walk,
    output logic             ped_ack,
    output logic             ped_pend,
    output logic [CNT_W-1:0] remain,
    output logic             phase_end,
    output logic [2:0]       state
);

    localparam int T_MAX = 1 << CNT_W;

    // Every duration must fit the counter once reduced by one, and be non-zero.
    if (T_MGREEN   < 1 || T_MGREEN   > T_MAX ||
        T_CGREEN   < 1 || T_CGREEN   > T_MAX ||
        T_YELLOW   < 1 || T_YELLOW   > T_MAX ||
        T_ALLRED   < 1 || T_ALLRED   > T_MAX ||
        T_PED      < 1 || T_PED      > T_MAX ||
        FLASH_HALF < 1 || FLASH_HALF > T_MAX) begin : g_bad_timing
        $error("sem_param_ctrl: every duration must lie in 1..2**CNT_W");
    end

    // Counter reload values (duration minus one).
    localparam logic [CNT_W-1:0] L_MGREEN = CNT_W'(T_MGREEN - 1);
    localparam logic [CNT_W-1:0] L_CGREEN = CNT_W'(T_CGREEN - 1);
    localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] L_PED    = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] L_FLASH  = CNT_W'(FLASH_HALF - 1);

    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_AR1 = 3'd2,
        S_CG  = 3'd3,
        S_CY  = 3'd4,
        S_AR2 = 3'd5,
        S_PED = 3'd6,
        S_FL  = 3'd7
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_remain;
    logic             r_ped_pend;
    logic             r_ped_ack;
    logic             r_flash_ph;
    logic             w_phase_end;

    assign w_phase_end = (r_remain == '0);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state    <= S_MG;
            r_remain   <= L_MGREEN;
            r_ped_pend <= 1'b0;
            r_ped_ack  <= 1'b0;
            r_flash_ph <= 1'b0;
        end else begin
            r_ped_ack <= 1'b0;

            if (flash && r_state != S_FL) begin
                // Maintenance mode discards whatever was left of the phase.
                r_state    <= S_FL;
                r_remain   <= L_FLASH;
                r_flash_ph <= 1'b1;
            end else if (r_state == S_FL) begin
                if (!flash) begin
                    r_state  <= S_AR2;
                    r_remain <= L_ALLRED;
                end else if (w_phase_end) begin
                    r_flash_ph <= ~r_flash_ph;
                    r_remain   <= L_FLASH;
                end else begin
                    r_remain <= r_remain - 1'b1;
                end
            end else if (w_phase_end) begin
                unique case (r_state)
                    S_MG:  begin r_state <= S_MY;  r_remain <= L_YELLOW; end
                    S_MY:  begin r_state <= S_AR1; r_remain <= L_ALLRED; end
                    S_AR1: begin r_state <= S_CG;  r_remain <= L_CGREEN; end
                    S_CG:  begin r_state <= S_CY;  r_remain <= L_YELLOW; end
                    S_CY:  begin r_state <= S_AR2; r_remain <= L_ALLRED; end
                    S_AR2: begin
                        if (r_ped_pend) begin
                            r_state    <= S_PED;
                            r_remain   <= L_PED;
                            r_ped_pend <= 1'b0;
                            r_ped_ack  <= 1'b1;
                        end else begin
                            r_state  <= S_MG;
                            r_remain <= L_MGREEN;
                        end
                    end
                    default: begin r_state <= S_MG; r_remain <= L_MGREEN; end
                endcase
            end else begin
                r_remain <= r_remain - 1'b1;
            end

            // Placed after the clear above: a request arriving on the serving
            // edge wins and is carried into the next round.
            if (ped_req) begin
                r_ped_pend <= 1'b1;
            end
        end
    end

    // Lamp decode from the state register only.
    // NOTE: every output gets a default first so this block cannot infer latches.
    always_comb begin
        main_r   = 1'b0;
        main_y   = 1'b0;
        main_g   = 1'b0;
        cross_r  = 1'b0;
        cross_y  = 1'b0;
        cross_g  = 1'b0;
        ped_walk = 1'b0;
        unique case (r_state)
            S_MG:  begin main_g = 1'b1; cross_r = 1'b1; end
            S_MY:  begin main_y = 1'b1; cross_r = 1'b1; end
            S_AR1,
            S_AR2: begin main_r = 1'b1; cross_r = 1'b1; end
            S_CG:  begin main_r = 1'b1; cross_g = 1'b1; end
            S_CY:  begin main_r = 1'b1; cross_y = 1'b1; end
            S_PED: begin main_r = 1'b1; cross_r = 1'b1; ped_walk = 1'b1; end
            S_FL:  begin main_y = r_flash_ph; cross_y = r_flash_ph; end
            default: begin main_r = 1'b1; cross_r = 1'b1; end
        endcase
    end

    assign ped_ack   = r_ped_ack;
    assign ped_pend  = r_ped_pend;
    assign remain    = r_remain;
    assign phase_end = w_phase_end;
    assign state     = r_state;

endmodule

// File: tb/tb_sem_param_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sem_param_ctrl
//   Directed bench for sem_param_ctrl. Cycle k is the cycle whose inputs are
//   sampled at the k-th rising edge after reset is released; outputs for
//   cycle k are observed 1 time unit after the previous edge.
//   u_dut uses default timing; u_dut6 uses CNT_W=3, T_ALLRED=1.
// ---------------------------------------------------------------------------
module tb_sem_param_ctrl;

    logic       ck = 1'b0;
    logic       rst, flash, ped_req;
    logic       main_r, main_y, main_g, cross_r, cross_y, cross_g;
    logic       ped_walk, ped_ack, ped_pend, phase_end;
    logic [4:0] remain;
    logic [2:0] state;

    logic       rst6, flash6, ped_req6;
    logic       m6_r, m6_y, m6_g, c6_r, c6_y, c6_g;
    logic       walk6, ack6, pend6, pe6;
    logic [2:0] remain6;
    logic [2:0] state6;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    sem_param_ctrl u_dut (
        .ck(ck), .rst(rst), .flash(flash), .ped_req(ped_req),
        .main_r(main_r), .main_y(main_y), .main_g(main_g),
        .cross_r(cross_r), .cross_y(cross_y), .cross_g(cross_g),
        .ped_walk(ped_walk), .ped_ack(ped_ack), .ped_pend(ped_pend),
        .remain(remain), .phase_end(phase_end), .state(state)
    );

    sem_param_ctrl #(.CNT_W(3), .T_MGREEN(8), .T_ALLRED(1)) u_dut6 (
        .ck(ck), .rst(rst6), .flash(flash6), .ped_req(ped_req6),
        .main_r(m6_r), .main_y(m6_y), .main_g(m6_g),
        .cross_r(c6_r), .cross_y(c6_y), .cross_g(c6_g),
        .ped_walk(walk6), .ped_ack(ack6), .ped_pend(pend6),
        .remain(remain6), .phase_end(pe6), .state(state6)
    );

    wire [6:0] lamps  = {main_r, main_y, main_g, cross_r, cross_y, cross_g, ped_walk};
    wire [6:0] lamps6 = {m6_r, m6_y, m6_g, c6_r, c6_y, c6_g, walk6};

    // Expected lamps {mr,my,mg,cr,cy,cg,walk} for a state code (spec table).
    function automatic logic [6:0] lamp_exp(input int st, input logic y);
        case (st)
            0: return 7'b001_100_0;
            1: return 7'b010_100_0;
            2, 5: return 7'b100_100_0;
            3: return 7'b100_001_0;
            4: return 7'b100_010_0;
            6: return 7'b100_100_1;
            default: return {1'b0, y, 1'b0, 1'b0, y, 1'b0, 1'b0};
        endcase
    endfunction

    // Free-run schedule with default timing, cycles 0..24.
    function automatic int st1(input int k);
        if (k < 8)  return 0;
        if (k < 11) return 1;
        if (k < 13) return 2;
        if (k < 19) return 3;
        if (k < 22) return 4;
        if (k < 24) return 5;
        return 0;
    endfunction

    function automatic int rem1(input int k);
        if (k < 8)  return 7 - k;
        if (k < 11) return 2 - (k - 8);
        if (k < 13) return 1 - (k - 11);
        if (k < 19) return 5 - (k - 13);
        if (k < 22) return 2 - (k - 19);
        if (k < 24) return 1 - (k - 22);
        return 7 - (k - 24);
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flash = 1'b0; ped_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        do_reset();
        checks++; if (lamps !== 7'b001_100_0) begin errors++; $display("FAIL reset_lamps got=%b exp=%b", lamps, 7'b001_100_0); end
        checks++; if (remain !== 5'd7) begin errors++; $display("FAIL reset_remain got=%0d exp=7", remain); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (ped_pend !== 1'b0) begin errors++; $display("FAIL reset_ped_pend got=%b exp=0", ped_pend); end
        checks++; if (ped_ack !== 1'b0) begin errors++; $display("FAIL reset_ped_ack got=%b exp=0", ped_ack); end
        checks++; if (phase_end !== 1'b0) begin errors++; $display("FAIL reset_phase_end got=%b exp=0", phase_end); end
    endtask

    task automatic test_free_run();
        logic exp_pe;
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            exp_pe = (k == 7 || k == 10 || k == 12 || k == 18 || k == 21 || k == 23);
            checks++; if (state !== 3'(st1(k))) begin errors++; $display("FAIL free_state c%0d got=%0d exp=%0d", k, state, st1(k)); end
            checks++; if (remain !== 5'(rem1(k))) begin errors++; $display("FAIL free_remain c%0d got=%0d exp=%0d", k, remain, rem1(k)); end
            checks++; if (phase_end !== exp_pe) begin errors++; $display("FAIL free_phase_end c%0d got=%b exp=%b", k, phase_end, exp_pe); end
            checks++; if (lamps !== lamp_exp(st1(k), 1'b0)) begin errors++; $display("FAIL free_lamps c%0d got=%b exp=%b", k, lamps, lamp_exp(st1(k), 1'b0)); end
            tick();
        end
    endtask

    task automatic test_ped();
        logic e_pend, e_walk, e_ack;
        do_reset();
        for (int k = 0; k <= 29; k++) begin
            ped_req = (k == 3);
            e_pend = (k >= 4 && k <= 23);
            e_walk = (k >= 24 && k <= 28);
            e_ack  = (k == 24);
            checks++; if (ped_pend !== e_pend) begin errors++; $display("FAIL ped_pend c%0d got=%b exp=%b", k, ped_pend, e_pend); end
            checks++; if (ped_walk !== e_walk) begin errors++; $display("FAIL ped_walk c%0d got=%b exp=%b", k, ped_walk, e_walk); end
            checks++; if (ped_ack !== e_ack) begin errors++; $display("FAIL ped_ack c%0d got=%b exp=%b", k, ped_ack, e_ack); end
            if (k >= 24 && k <= 28) begin
                checks++; if (lamps !== 7'b100_100_1 || state !== 3'd6) begin errors++; $display("FAIL ped_phase c%0d lamps=%b state=%0d exp lamps=1001001 state=6", k, lamps, state); end
                checks++; if (remain !== 5'(28 - k)) begin errors++; $display("FAIL ped_remain c%0d got=%0d exp=%0d", k, remain, 28 - k); end
            end
            if (k == 29) begin
                checks++; if (lamps !== 7'b001_100_0 || remain !== 5'd7) begin errors++; $display("FAIL ped_resume lamps=%b remain=%0d exp lamps=0011000 remain=7", lamps, remain); end
            end
            tick();
        end
        ped_req = 1'b0;
    endtask

    task automatic test_flash();
        logic       y;
        logic [6:0] e_l;
        do_reset();
        for (int k = 0; k <= 33; k++) begin
            flash = (k >= 5 && k <= 29);
            if (k >= 6 && k <= 30) begin
                y   = (((k - 6) / 4) % 2 == 0);
                e_l = {1'b0, y, 1'b0, 1'b0, y, 1'b0, 1'b0};
                checks++; if (state !== 3'd7) begin errors++; $display("FAIL flash_state c%0d got=%0d exp=7", k, state); end
                checks++; if (lamps !== e_l) begin errors++; $display("FAIL flash_lamps c%0d got=%b exp=%b", k, lamps, e_l); end
                checks++; if (remain !== 5'(3 - ((k - 6) % 4))) begin errors++; $display("FAIL flash_remain c%0d got=%0d exp=%0d", k, remain, 3 - ((k - 6) % 4)); end
            end else if (k == 31 || k == 32) begin
                checks++; if (state !== 3'd5 || lamps !== 7'b100_100_0) begin errors++; $display("FAIL flash_exit_ar2 c%0d state=%0d lamps=%b exp state=5 lamps=1001000", k, state, lamps); end
            end else if (k == 33) begin
                checks++; if (state !== 3'd0 || lamps !== 7'b001_100_0) begin errors++; $display("FAIL flash_exit_mg state=%0d lamps=%b exp state=0 lamps=0011000", state, lamps); end
            end
            tick();
        end
        flash = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            ped_req = (k == 2);
            rst     = (k == 15);
            if (k == 15) begin
                checks++; if (state !== 3'd3 || ped_pend !== 1'b1) begin errors++; $display("FAIL rstmid_pre state=%0d pend=%b exp state=3 pend=1", state, ped_pend); end
            end
            if (k == 16) begin
                checks++; if (state !== 3'd0 || remain !== 5'd7 || ped_pend !== 1'b0 || lamps !== 7'b001_100_0) begin
                    errors++; $display("FAIL rstmid_post state=%0d remain=%0d pend=%b lamps=%b exp 0/7/0/0011000", state, remain, ped_pend, lamps);
                end
            end
            if (k > 16) begin
                checks++; if (ped_walk !== 1'b0) begin errors++; $display("FAIL rstmid_no_walk c%0d got=%b exp=0", k, ped_walk); end
            end
            if (k == 40) begin
                checks++; if (state !== 3'd0 || remain !== 5'd7) begin errors++; $display("FAIL rstmid_round state=%0d remain=%0d exp state=0 remain=7", state, remain); end
            end
            tick();
        end
        rst = 1'b0; ped_req = 1'b0;
    endtask

    task automatic test_ped_held();
        logic e_walk;
        do_reset();
        for (int k = 0; k <= 58; k++) begin
            ped_req = (k == 3) || (k >= 20 && k <= 28);
            e_walk  = (k >= 24 && k <= 28) || (k >= 53 && k <= 57);
            checks++; if (ped_walk !== e_walk) begin errors++; $display("FAIL held_walk c%0d got=%b exp=%b", k, ped_walk, e_walk); end
            if (k == 24 || k == 53) begin
                checks++; if (ped_ack !== 1'b1) begin errors++; $display("FAIL held_ack c%0d got=%b exp=1", k, ped_ack); end
            end
            if (k == 24) begin
                checks++; if (ped_pend !== 1'b1) begin errors++; $display("FAIL held_pend_relatch got=%b exp=1", ped_pend); end
            end
            if (k == 52) begin
                checks++; if (state !== 3'd5 || ped_pend !== 1'b1) begin errors++; $display("FAIL held_ar2 state=%0d pend=%b exp state=5 pend=1", state, ped_pend); end
            end
            if (k == 53) begin
                checks++; if (ped_pend !== 1'b0) begin errors++; $display("FAIL held_pend_clear got=%b exp=0", ped_pend); end
            end
            if (k == 58) begin
                checks++; if (state !== 3'd0) begin errors++; $display("FAIL held_resume state=%0d exp=0", state); end
            end
            tick();
        end
        ped_req = 1'b0;
    endtask

    task automatic test_short_allred();
        int   st;
        int   rm;
        logic e_pe;
        rst6 = 1'b1;
        tick();
        rst6 = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            if (k < 8)       begin st = 0; rm = 7 - k;        end
            else if (k < 11) begin st = 1; rm = 2 - (k - 8);  end
            else if (k < 12) begin st = 2; rm = 0;            end
            else if (k < 18) begin st = 3; rm = 5 - (k - 12); end
            else if (k < 21) begin st = 4; rm = 2 - (k - 18); end
            else if (k < 22) begin st = 5; rm = 0;            end
            else             begin st = 0; rm = 7;            end
            e_pe = (rm == 0);
            checks++; if (state6 !== 3'(st) || remain6 !== 3'(rm)) begin errors++; $display("FAIL short_seq c%0d state=%0d remain=%0d exp state=%0d remain=%0d", k, state6, remain6, st, rm); end
            checks++; if (pe6 !== e_pe) begin errors++; $display("FAIL short_phase_end c%0d got=%b exp=%b", k, pe6, e_pe); end
            checks++; if (lamps6 !== lamp_exp(st, 1'b0)) begin errors++; $display("FAIL short_lamps c%0d got=%b exp=%b", k, lamps6, lamp_exp(st, 1'b0)); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; flash = 1'b0; ped_req = 1'b0;
        rst6 = 1'b1; flash6 = 1'b0; ped_req6 = 1'b0;
        #1;
        test_reset();
        test_free_run();
        test_ped();
        test_flash();
        test_reset_mid();
        test_ped_held();
        test_short_allred();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
